// File: rtl/dcache_mem_axi_bridge.sv
// dcache_mem_axi_bridge: single-beat AXI4-Lite master behind the uncached D-cache port.
// Define WRITE_RESP_WAIT_EN to hold write addrOK until the B response (strongly ordered writes).
module dcache_mem_axi_bridge #(
  parameter int offset_width = 2
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [31:0]                         addr_dcache_mem,
  input  logic [31:0]                         dout_dcache_mem,
  output logic [32*(2<<offset_width)-1:0]     din_mem_dcache,
  input  logic                                dcache_mem_req,
  input  logic                                dcache_mem_wr,
  input  logic [1:0]                          dcache_mem_size,
  input  logic [3:0]                          dcache_mem_wstrb,
  output logic                                mem_dcache_addrOK,
  output logic                                mem_dcache_dataOK,
  output logic [31:0]                         araddr,
  output logic [2:0]                          arsize,
  output logic                                arvalid,
  input  logic                                arready,
  input  logic [31:0]                         rdata,
  input  logic [1:0]                          rresp,
  input  logic                                rvalid,
  output logic                                rready,
  output logic [31:0]                         awaddr,
  output logic [2:0]                          awsize,
  output logic                                awvalid,
  input  logic                                awready,
  output logic [31:0]                         wdata,
  output logic [3:0]                          wstrb,
  output logic                                wvalid,
  input  logic                                wready,
  input  logic [1:0]                          bresp,
  input  logic                                bvalid,
  output logic                                bready,
  output logic                                bus_err
);
  localparam int dw = 32*(2<<offset_width);
  typedef enum logic [2:0] {IDLE, AR, R, RD, AWW, B} state_t;
  state_t state, state_n;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0] size_q;
  logic [3:0] wstrb_q;
  logic aw_done, w_done, aw_hs, w_hs, ww_done;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    arvalid = state == AR;
    rready = state == R;
    awvalid = state == AWW && !aw_done;
    wvalid = state == AWW && !w_done;
    bready = state == B;
    mem_dcache_dataOK = state == RD;
    aw_hs = awvalid && awready;
    w_hs = wvalid && wready;
    ww_done = state == AWW && (aw_done || aw_hs) && (w_done || w_hs);
`ifdef WRITE_RESP_WAIT_EN
    mem_dcache_addrOK = (arvalid && arready) || (bready && bvalid);
`else
    mem_dcache_addrOK = (arvalid && arready) || ww_done;
`endif
    state_n = state;
    case (state)
      IDLE: if (dcache_mem_req) state_n = dcache_mem_wr ? AWW : AR;
      AR: if (arready) state_n = R;
      R: if (rvalid) state_n = RD;
      RD: state_n = IDLE;
      AWW: if (ww_done) state_n = B;
      B: if (bvalid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // aw_done/w_done self-clear on the cycle both halves finish, so they are zero on B entry
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q <= '0;
      wdata_q <= '0;
      size_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      bus_err <= 1'b0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      if (state == IDLE && dcache_mem_req) begin
        addr_q <= addr_dcache_mem;
        wdata_q <= dout_dcache_mem;
        size_q <= dcache_mem_size;
        wstrb_q <= dcache_mem_wstrb;
      end
      if (rvalid && rready) rdata_q <= rdata;
      bus_err <= bus_err || (rvalid && rready && |rresp) || (bvalid && bready && |bresp);
      aw_done <= state == AWW && !ww_done && (aw_done || aw_hs);
      w_done <= state == AWW && !ww_done && (w_done || w_hs);
    end
  end
  assign araddr = addr_q;
  assign awaddr = addr_q;
  assign arsize = {1'b0, size_q};
  assign awsize = {1'b0, size_q};
  assign wdata = wdata_q;
  assign wstrb = wstrb_q;
  assign din_mem_dcache = {{(dw-32){1'b0}}, rdata_q};
endmodule

// File: tb/tb_dcache_mem_axi_bridge.sv
// tb_dcache_mem_axi_bridge: directed bench with a transaction-level model of the bridge.
module tb_dcache_mem_axi_bridge;
  logic clk = 0, rstn = 0;
  logic [31:0] addr = 0, dout = 0;
  logic [255:0] din;
  logic req = 0, wr = 0;
  logic [1:0] size = 0;
  logic [3:0] strb = 0;
  logic addr_ok, data_ok;
  logic [31:0] araddr, awaddr, wdata;
  logic [2:0] arsize, awsize;
  logic arvalid, rready, awvalid, wvalid, bready, bus_err;
  logic [3:0] wstrb;
  logic arready = 0, rvalid = 0, awready = 0, wready = 0, bvalid = 0;
  logic [31:0] rdata = 0;
  logic [1:0] rresp = 0, bresp = 0;

  always #5 clk = ~clk;

  dcache_mem_axi_bridge dut (
    .clk(clk), .rstn(rstn), .addr_dcache_mem(addr), .dout_dcache_mem(dout),
    .din_mem_dcache(din), .dcache_mem_req(req), .dcache_mem_wr(wr),
    .dcache_mem_size(size), .dcache_mem_wstrb(strb),
    .mem_dcache_addrOK(addr_ok), .mem_dcache_dataOK(data_ok),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .bus_err(bus_err)
  );

  typedef struct {
    logic wr;
    logic [31:0] addr, data;
    logic [1:0] size;
    logic [3:0] strb;
  } req_t;
  req_t q[$];

  int checks = 0, errors = 0;
  int aok_cnt = 0, dok_cnt = 0, done_cnt = 0;
  logic ar_seen = 0, aw_seen = 0, w_seen = 0, aok_done = 0, dok_due = 0, err_exp = 0;
  logic [31:0] din_exp = 0;

  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [31:0] rdata_cfg = 0;
  logic [1:0] rresp_cfg = 0, bresp_cfg = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // AXI slave with per-channel ready/valid latency counted from the master's request
  initial begin : slave
    int ar_c, r_c, aw_c, w_c, b_c;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rstn) begin
        ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
      end else begin
        arready = arvalid && ar_c >= ar_dly;
        ar_c = arvalid ? ar_c + 1 : 0;
        rvalid = rready && r_c >= r_dly;
        r_c = rready ? r_c + 1 : 0;
        rdata = rdata_cfg;
        rresp = rresp_cfg;
        awready = awvalid && aw_c >= aw_dly;
        aw_c = awvalid ? aw_c + 1 : 0;
        wready = wvalid && w_c >= w_dly;
        w_c = wvalid ? w_c + 1 : 0;
        bvalid = bready && b_c >= b_dly;
        b_c = bready ? b_c + 1 : 0;
        bresp = bresp_cfg;
      end
    end
  end

  // model: head of q is the transaction the bridge must be working on
  initial begin : monitor
    req_t h;
    logic hr, hw, exp_aok;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        chk("reset_outputs", {arvalid, rready, awvalid, wvalid, bready, addr_ok, data_ok}, 0);
        q.delete();
        {ar_seen, aw_seen, w_seen, aok_done, dok_due, err_exp} = 0;
        din_exp = 0;
      end else begin
        hr = q.size() > 0 && !q[0].wr;
        hw = q.size() > 0 && q[0].wr;
        if (q.size() > 0) h = q[0];
`ifdef WRITE_RESP_WAIT_EN
        exp_aok = !aok_done && ((hr && arvalid && arready) || (hw && bvalid && bready));
`else
        exp_aok = !aok_done && ((hr && arvalid && arready) ||
                  (hw && (aw_seen || (awvalid && awready)) && (w_seen || (wvalid && wready))));
`endif
        chk("addrOK", addr_ok, exp_aok);
        chk("dataOK", data_ok, dok_due);
        chk("din", din, {224'b0, din_exp});
        chk("bus_err", bus_err, err_exp);
        if (arvalid) chk("ar_chan", {hr && !ar_seen, araddr, arsize}, {1'b1, h.addr, 1'b0, h.size});
        if (rready) chk("r_ctx", {hr, ar_seen}, 2'b11);
        if (awvalid) chk("aw_chan", {hw && !aw_seen, awaddr, awsize}, {1'b1, h.addr, 1'b0, h.size});
        if (wvalid) chk("w_chan", {hw && !w_seen, wdata, wstrb}, {1'b1, h.data, h.strb});
        if (bready) chk("b_ctx", {hw, aw_seen, w_seen}, 3'b111);
        if (addr_ok) begin aok_cnt++; aok_done = 1; end
        if (arvalid && arready) ar_seen = 1;
        if (awvalid && awready) aw_seen = 1;
        if (wvalid && wready) w_seen = 1;
        dok_due = rvalid && rready;
        if (rvalid && rready) begin
          din_exp = rdata;
          err_exp = err_exp | (rresp != 0);
        end
        if (data_ok || (bvalid && bready)) begin
          if (bvalid && bready) err_exp = err_exp | (bresp != 0);
          if (data_ok) dok_cnt++;
          done_cnt++;
          if (q.size() > 0) void'(q.pop_front());
          {ar_seen, aw_seen, w_seen, aok_done} = 0;
        end
      end
    end
  end

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] s, input logic [3:0] st, input bit hold, output int cyc);
    req_t t;
    t.wr = w; t.addr = a; t.data = d; t.size = s; t.strb = st;
    q.push_back(t);
    req = 1; wr = w; addr = a; dout = d; size = s; strb = st;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!addr_ok && cyc < 200);
    if (!addr_ok) chk("addrOK_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!hold) req = 0;
  endtask

  task automatic wait_done(input int n);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (done_cnt < n && k < 200);
    if (done_cnt < n) chk("done_timeout", done_cnt, n);
  endtask

  initial begin : main
    int cyc, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_din", din, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready, addr_ok, data_ok}, 0);
    rstn = 1;
    @(posedge clk);
    #1;
    // plain read
    ar_dly = 0; r_dly = 3; rdata_cfg = 32'hDEADBEEF; rresp_cfg = 0;
    do_req(0, 32'h1C00_0010, 0, 2'd2, 4'hF, 0, cyc);
    chk("rd1_aok_cycle", cyc, 2);
    wait_done(1);
    chk("rd1_data", din[31:0], 32'hDEADBEEF);
    chk("rd1_upper", din[255:32], 0);
    chk("rd1_err", bus_err, 0);
    chk("rd1_counts", {aok_cnt[7:0], dok_cnt[7:0]}, {8'd1, 8'd1});
    // write, AW accepted two cycles ahead of W
    aw_dly = 0; w_dly = 2; b_dly = 1; bresp_cfg = 0;
    do_req(1, 32'h0000_0104, 32'h11223344, 2'd0, 4'b0010, 0, cyc);
`ifdef WRITE_RESP_WAIT_EN
    chk("wr1_aok_cycle", cyc, 6);
`else
    chk("wr1_aok_cycle", cyc, 4);
`endif
    wait_done(2);
    chk("wr1_awaddr", awaddr, 32'h0000_0104);
    chk("wr1_wdata", {wdata, wstrb}, {32'h11223344, 4'b0010});
    chk("wr1_counts", {aok_cnt[7:0], dok_cnt[7:0]}, {8'd2, 8'd1});
    // same write, slow B response
    b_dly = 5;
    do_req(1, 32'h0000_0104, 32'h11223344, 2'd0, 4'b0010, 0, cyc);
`ifdef WRITE_RESP_WAIT_EN
    chk("wr2_aok_cycle", cyc, 10);
`else
    chk("wr2_aok_cycle", cyc, 4);
`endif
    wait_done(3);
    // SLVERR read then OKAY read: bus_err is sticky
    ar_dly = 2; r_dly = 0; rdata_cfg = 32'hCAFE0001; rresp_cfg = 2'b10;
    do_req(0, 32'h1C00_0020, 0, 2'd1, 4'h3, 0, cyc);
    chk("rd2_aok_cycle", cyc, 4);
    wait_done(4);
    chk("rd2_err", bus_err, 1);
    chk("rd2_data", din[31:0], 32'hCAFE0001);
    rresp_cfg = 0; rdata_cfg = 32'h55AA_00FF; ar_dly = 1; r_dly = 2;
    do_req(0, 32'h1C00_0024, 0, 2'd2, 4'hF, 0, cyc);
    wait_done(5);
    chk("rd3_err_sticky", bus_err, 1);
    chk("rd3_data", din[31:0], 32'h55AA_00FF);
    chk("rd_dok_count", dok_cnt, 3);
    // write then read with req held through B
    aw_dly = 1; w_dly = 0; b_dly = 2; ar_dly = 0; r_dly = 1; rdata_cfg = 32'h0BADF00D;
    n = aok_cnt;
    do_req(1, 32'h0000_0200, 32'hA5A5_5A5A, 2'd2, 4'hF, 1, cyc);
    do_req(0, 32'h0000_0300, 0, 2'd2, 4'hF, 0, cyc);
    wait_done(7);
    chk("b2b_aok", aok_cnt - n, 2);
    chk("b2b_data", din[31:0], 32'h0BADF00D);
    // reset during AWW
    aw_dly = 50; w_dly = 50;
    n = 0;
    q.push_back('{wr: 1'b1, addr: 32'h400, data: 32'h77, size: 2'd2, strb: 4'hF});
    req = 1; wr = 1; addr = 32'h400; dout = 32'h77; size = 2'd2; strb = 4'hF;
    do begin
      @(negedge clk);
      n++;
    end while (!awvalid && n < 20);
    chk("rst_mid_awvalid_up", awvalid, 1);
    @(posedge clk);
    #1;
    req = 0;
    rstn = 0;
    #1;
    chk("rst_mid_valids", {arvalid, awvalid, wvalid, rready, bready, addr_ok, data_ok}, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1;
    n = aok_cnt + dok_cnt;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_no_completion", aok_cnt + dok_cnt, n);
    chk("rst_err_cleared", bus_err, 0);
    chk("rst_din_cleared", din, 0);
    // bridge is idle again and serves a read
    aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0; rdata_cfg = 32'h1357_9BDF;
    n = done_cnt;
    do_req(0, 32'h1C00_0040, 0, 2'd2, 4'hF, 0, cyc);
    chk("post_rst_aok_cycle", cyc, 2);
    wait_done(n + 1);
    chk("post_rst_data", din[31:0], 32'h1357_9BDF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/dcache_mem_axi_bridge.md
Name: dcache_mem_axi_bridge

Overview:
- Memory-side neighbour of the uncached D-cache stage. Consumes its single-word req/addrOK/dataOK/wr/size/wstrb handshake and drives one single-beat AXI4-Lite-style master (AR/R/AW/W/B channels, no len/burst/id).
- One transaction at a time; registered read data is returned on the cache's line-wide data bus.

Parameters:
offset_width, 2, line offset width; return bus width = 32*(2<<offset_width) (256 bits at default)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
addr_dcache_mem  in  32  request address
dout_dcache_mem  in  32  write data
din_mem_dcache  out  32*(2<<offset_width)  read data; word in [31:0], upper bits 0
dcache_mem_req  in  1  request, held until addrOK
dcache_mem_wr  in  1  0-read 1-write
dcache_mem_size  in  2  0-1B 1-2B 2-4B
dcache_mem_wstrb  in  4  byte write enables
mem_dcache_addrOK  out  1  request accepted, one-cycle pulse
mem_dcache_dataOK  out  1  read data valid, one-cycle pulse
araddr  out  32  AXI read address
arsize  out  3  {1'b0,size}
arvalid  out  1  AXI AR valid
arready  in  1  AXI AR ready
rdata  in  32  AXI read data
rresp  in  2  AXI read response
rvalid  in  1  AXI R valid
rready  out  1  AXI R ready
awaddr  out  32  AXI write address
awsize  out  3  {1'b0,size}
awvalid  out  1  AXI AW valid
awready  in  1  AXI AW ready
wdata  out  32  AXI write data
wstrb  out  4  AXI write strobes
wvalid  out  1  AXI W valid
wready  in  1  AXI W ready
bresp  in  2  AXI write response
bvalid  in  1  AXI B valid
bready  out  1  AXI B ready
bus_err  out  1  sticky; set by nonzero rresp/bresp

Behaviour:
- Reset (async, rstn low): state IDLE. All valid/ready/OK outputs 0, data register 0, bus_err 0, aw_done/w_done 0. Asserting reset mid-transaction drops all valids at once; no completion is reported.
- IDLE: on dcache_mem_req, latch addr/wdata/size/wstrb/wr into registers; next state AR (wr=0) or AWW (wr=1). AXI outputs are driven only from the latched registers.
- AR: arvalid=1. On arready: arvalid drops next cycle; addrOK pulses in the handshake cycle (combinational from arready & state); next state R.
- R: rready=1. On rvalid, load rdata into din_mem_dcache[31:0] and OR (rresp!=0) into bus_err. dataOK pulses in the following cycle, then return to IDLE.
- Read data register holds until the next R handshake. The cache samples it in the cycle after dataOK, so it must stay stable then.
- AWW: awvalid and wvalid asserted together. Each drops independently after its own handshake (tracked by aw_done/w_done); the two may complete in either order or in the same cycle. When both are done, go to B.
- B: bready=1. On bvalid, OR (bresp!=0) into bus_err and return to IDLE. dataOK is never pulsed for writes.
- Write addrOK timing depends on WRITE_RESP_WAIT_EN (below).
- No new request is latched outside IDLE. A req arriving during B or R waits; the bridge latches it on IDLE entry. Minimum read: IDLE, AR (arready=1), R (rvalid=1), 1 dataOK cycle = 4 cycles.
- Address and size are passed unaligned and unchecked. Upper bits of din_mem_dcache are always 0.

Optional Feature:
- Macro WRITE_RESP_WAIT_EN.
- Undefined (posted writes): write addrOK pulses in the cycle the last of the AW/W handshakes completes.
- Defined (strongly ordered, for MMIO): write addrOK pulses in the bvalid&bready cycle instead. The cache stalls until the B response.
- In both cases the bridge waits for B before accepting the next request.

Test Plan:
- Read 0x1C00_0010, arready=1, rvalid=1 after 3 cycles, rdata=0xDEADBEEF -> addrOK 1 cycle; dataOK exactly 1 cycle; din[31:0]=0xDEADBEEF, din upper bits 0; bus_err=0.
- Write 0x0000_0104, data 0x11223344, wstrb=4'b0010, awready 2 cycles before wready -> awaddr/wdata/wstrb exact; awvalid drops first; addrOK when W completes (macro off); bready until bvalid.
- Same write with WRITE_RESP_WAIT_EN, bvalid 5 cycles later -> addrOK coincident with the B handshake, never earlier.
- Read with rresp=2'b10 -> dataOK still pulses; bus_err=1 and stays 1 through a following OKAY read.
- Back-to-back write then read with req held high during B -> read AR issued only after B completes; one addrOK per request.
- rstn low while in AWW with awvalid=1 -> all valids 0 immediately; after release the state is IDLE and no addrOK/dataOK appears.
